tile_prefetcher: RTL and testbench

Loader on the write side of the double-buffered tile buffer. It accepts a tile descriptor, streams the tile row-major out of a fixed-latency source SRAM, and writes it into the tile buffer's prefetch bank through the DMA write port. Once the tile is loaded and the compute side has finished its current tile, it issues the single-cycle bank `swap` pulse. It sits between the GEMM controller's descriptor queue and `tile_buffer`.

---
 rtl/tile_prefetch_pkg.sv | 19 +
 rtl/tile_addr_gen.sv | 74 +++++++
 rtl/tile_prefetcher.sv | 150 +++++++++++++++
 tb/tb_tile_prefetcher.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_prefetch_pkg.sv
// Shared types and helpers for the tile prefetcher: FSM state encoding,
// default tile edge and descriptor-field clamping.
package tile_prefetch_pkg;

    localparam int TILE_DIM_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        LOADED,
        SWAP
    } state_t;

    function automatic int clamp_dim(input int value, input int limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Row-major walk over a tile: row/col counters, source address accumulator
// (stride added once per row) and bank element index.
module tile_addr_gen #(
    parameter int TILE_DIM   = 16,
    parameter int CW         = 5,
    parameter int AW         = 8,
    parameter int SRC_ADDR_W = 16,
    parameter bit FULL_WALK  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [SRC_ADDR_W-1:0] base,
    input  logic [SRC_ADDR_W-1:0] stride,
    input  logic [CW-1:0]         rows,
    input  logic [CW-1:0]         cols,
    output logic [SRC_ADDR_W-1:0] src_addr,
    output logic [AW-1:0]         bank_idx,
    output logic                  last,
    output logic                  in_bounds
);

    logic [CW-1:0]         row_reg;
    logic [CW-1:0]         col_reg;
    logic [CW-1:0]         rows_reg;
    logic [CW-1:0]         cols_reg;
    logic [SRC_ADDR_W-1:0] row_addr_reg;
    logic [SRC_ADDR_W-1:0] stride_reg;
    logic [AW-1:0]         row_idx_reg;
    logic [CW-1:0]         row_lim;
    logic [CW-1:0]         col_lim;
    logic                  row_end;

    // With full walk the counters span the whole tile; bounds still track rows x cols.
    assign row_lim = FULL_WALK ? CW'(TILE_DIM) : rows_reg;
    assign col_lim = FULL_WALK ? CW'(TILE_DIM) : cols_reg;
    assign row_end = (col_reg == col_lim - CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_reg      <= '0;
            col_reg      <= '0;
            rows_reg     <= '0;
            cols_reg     <= '0;
            row_addr_reg <= '0;
            stride_reg   <= '0;
            row_idx_reg  <= '0;
        end else if (load) begin
            row_reg      <= '0;
            col_reg      <= '0;
            rows_reg     <= rows;
            cols_reg     <= cols;
            row_addr_reg <= base;
            stride_reg   <= stride;
            row_idx_reg  <= '0;
        end else if (step) begin
            if (row_end) begin
                col_reg      <= '0;
                row_reg      <= row_reg + CW'(1);
                row_addr_reg <= row_addr_reg + stride_reg;
                row_idx_reg  <= row_idx_reg + AW'(TILE_DIM);
            end else begin
                col_reg <= col_reg + CW'(1);
            end
        end
    end

    assign src_addr  = row_addr_reg + SRC_ADDR_W'(col_reg);
    assign bank_idx  = row_idx_reg + AW'(col_reg);
    assign last      = row_end && (row_reg == row_lim - CW'(1));
    assign in_bounds = (row_reg < rows_reg) && (col_reg < cols_reg);

endmodule

// File: rtl/tile_prefetcher.sv
// Loads one tile from the source SRAM into the prefetch bank, then issues a bank swap.
// Optional feature macro: TILE_PREFETCH_ZERO_PAD_EN (zero-fill outside rows x cols).
module tile_prefetcher
    import tile_prefetch_pkg::*;
#(
    parameter int TILE_DIM   = TILE_DIM_DEFAULT,
    parameter int BANK_DEPTH = 256,
    parameter int DATA_W     = 8,
    parameter int SRC_ADDR_W = 16,
    localparam int CW        = $clog2(TILE_DIM) + 1,
    localparam int AW        = $clog2(BANK_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [SRC_ADDR_W-1:0] desc_base,
    input  logic [SRC_ADDR_W-1:0] desc_stride,
    input  logic [CW-1:0]         desc_rows,
    input  logic [CW-1:0]         desc_cols,
    output logic                  src_rd_en,
    output logic [SRC_ADDR_W-1:0] src_rd_addr,
    input  logic [DATA_W-1:0]     src_rd_data,
    output logic                  dma_wr_en,
    output logic [AW-1:0]         dma_wr_addr,
    output logic [DATA_W-1:0]     dma_wr_data,
    input  logic                  consume_done,
    output logic                  swap,
    output logic                  tile_loaded,
    output logic                  busy
);

`ifdef TILE_PREFETCH_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    if (BANK_DEPTH != TILE_DIM * TILE_DIM) begin : g_depth_check
        $error("tile_prefetcher: BANK_DEPTH must equal TILE_DIM*TILE_DIM");
    end

    state_t          state_reg;
    state_t          state_next;
    logic            compute_empty_reg;
    logic            consume_pend_reg;
    logic            wr_en_reg;
    logic [AW-1:0]   wr_addr_reg;
    logic            wr_keep_reg;
    logic [CW-1:0]   rows_clamped;
    logic [CW-1:0]   cols_clamped;
    logic            accept;
    logic            step;
    logic            last;
    logic            in_bounds;
    logic [AW-1:0]   bank_idx;

    assign rows_clamped = CW'(clamp_dim(int'(desc_rows), TILE_DIM));
    assign cols_clamped = CW'(clamp_dim(int'(desc_cols), TILE_DIM));
    assign accept       = (state_reg == IDLE) && desc_valid;
    assign step         = (state_reg == FETCH);

    tile_addr_gen #(
        .TILE_DIM   (TILE_DIM),
        .CW         (CW),
        .AW         (AW),
        .SRC_ADDR_W (SRC_ADDR_W),
        .FULL_WALK  (ZERO_PAD)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (step),
        .base      (desc_base),
        .stride    (desc_stride),
        .rows      (rows_clamped),
        .cols      (cols_clamped),
        .src_addr  (src_rd_addr),
        .bank_idx  (bank_idx),
        .last      (last),
        .in_bounds (in_bounds)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (!ZERO_PAD && ((rows_clamped == '0) || (cols_clamped == '0))) begin
                        state_next = LOADED;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH:   if (last) state_next = DRAIN;
            DRAIN:   state_next = LOADED;
            LOADED:  if (compute_empty_reg || consume_pend_reg) state_next = SWAP;
            SWAP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        desc_ready  = (state_reg == IDLE);
        src_rd_en   = (state_reg == FETCH) && in_bounds;
        tile_loaded = (state_reg == LOADED);
        swap        = (state_reg == SWAP);
        busy        = (state_reg != IDLE);
    end

    // A consume_done coinciding with SWAP belongs to the tile being swapped out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            compute_empty_reg <= 1'b1;
            consume_pend_reg  <= 1'b0;
        end else if (state_reg == SWAP) begin
            compute_empty_reg <= 1'b0;
            consume_pend_reg  <= 1'b0;
        end else if (consume_done) begin
            consume_pend_reg  <= 1'b1;
        end
    end

    // Source data returns one cycle after the read; the bank index rides alongside.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_keep_reg <= 1'b0;
        end else begin
            wr_en_reg   <= step;
            wr_addr_reg <= bank_idx;
            wr_keep_reg <= in_bounds;
        end
    end

    assign dma_wr_en   = wr_en_reg;
    assign dma_wr_addr = wr_addr_reg;
    assign dma_wr_data = wr_keep_reg ? src_rd_data : '0;

endmodule

// File: tb/tb_tile_prefetcher.sv
// Bench for tile_prefetcher: directed and random tiles against a walk-list model.
module tb_tile_prefetcher;

    localparam int TD = 16;
    localparam int BD = 256;

`ifdef TILE_PREFETCH_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [15:0] desc_base = '0;
    logic [15:0] desc_stride = '0;
    logic [4:0]  desc_rows = '0;
    logic [4:0]  desc_cols = '0;
    logic        src_rd_en;
    logic [15:0] src_rd_addr;
    logic [7:0]  src_rd_data;
    logic        dma_wr_en;
    logic [7:0]  dma_wr_addr;
    logic [7:0]  dma_wr_data;
    logic        consume_done = 1'b0;
    logic        swap;
    logic        tile_loaded;
    logic        busy;

    always #5 clk = ~clk;

    tile_prefetcher #(
        .TILE_DIM   (TD),
        .BANK_DEPTH (BD),
        .DATA_W     (8),
        .SRC_ADDR_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .desc_valid   (desc_valid),
        .desc_ready   (desc_ready),
        .desc_base    (desc_base),
        .desc_stride  (desc_stride),
        .desc_rows    (desc_rows),
        .desc_cols    (desc_cols),
        .src_rd_en    (src_rd_en),
        .src_rd_addr  (src_rd_addr),
        .src_rd_data  (src_rd_data),
        .dma_wr_en    (dma_wr_en),
        .dma_wr_addr  (dma_wr_addr),
        .dma_wr_data  (dma_wr_data),
        .consume_done (consume_done),
        .swap         (swap),
        .tile_loaded  (tile_loaded),
        .busy         (busy)
    );

    int cyc = 0;
    // Source SRAM: one-cycle read latency, contents equal to the address LSBs.
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        src_rd_data <= src_rd_en ? src_rd_addr[7:0] : 8'hxx;
    end

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_bank [BD];
    logic [7:0]  dut_bank [BD];
    int          rd_cyc [$];
    logic [15:0] rd_addr [$];
    int          wr_cyc [$];
    logic [7:0]  wr_addr [$];
    logic [7:0]  wr_data [$];
    int          loaded_cyc;
    int          swap_cyc;
    int          nswap;
    int          ready_after;
    bit          prev_swap;
    bit          empty_m = 1'b1;

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        rd_cyc.delete(); rd_addr.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        loaded_cyc = -1; swap_cyc = -1; nswap = 0; ready_after = -1; prev_swap = 1'b0;
    endtask

    // Observe one cycle at the falling edge, then move to just after the next rising edge.
    task automatic sample();
        @(negedge clk);
        if (prev_swap && ready_after < 0) ready_after = int'(desc_ready);
        prev_swap = swap;
        if (src_rd_en) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(src_rd_addr);
        end
        if (dma_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(dma_wr_addr);
            wr_data.push_back(dma_wr_data);
            dut_bank[dma_wr_addr] = dma_wr_data;
        end
        if (tile_loaded && loaded_cyc < 0) loaded_cyc = cyc;
        if (swap) begin
            nswap++;
            if (swap_cyc < 0) swap_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    // cmode: 0 no consume, 1 consume during fetch, 2 consume ck cycles after LOADED.
    task automatic run_tile(input logic [15:0] base, input logic [15:0] stride,
                            input logic [4:0] rows, input logic [4:0] cols,
                            input int cmode, input int ck, input bit noise, input bit pulse_swap);
        int rr, cc, wrows, wcols, n, lc, p, s, c0, rel, mism, idx;
        int e_rd_rel [$];
        logic [15:0] e_rd_addr [$];
        int e_wr_rel [$];
        logic [7:0] e_wr_addr [$];
        logic [7:0] e_wr_data [$];
        logic [15:0] a;
        logic [7:0] d;
        bit ok;
        bit inb;

        rr = (int'(rows) > TD) ? TD : int'(rows);
        cc = (int'(cols) > TD) ? TD : int'(cols);
        wrows = PAD ? TD : rr;
        wcols = PAD ? TD : cc;
        idx = 0;
        for (int r = 0; r < wrows; r++) begin
            for (int c = 0; c < wcols; c++) begin
                a   = 16'(int'(base) + r * int'(stride) + c);
                inb = (r < rr) && (c < cc);
                d   = inb ? a[7:0] : 8'h00;
                if (inb) begin
                    e_rd_rel.push_back(idx + 1);
                    e_rd_addr.push_back(a);
                end
                e_wr_rel.push_back(idx + 2);
                e_wr_addr.push_back(8'(r * TD + c));
                e_wr_data.push_back(d);
                exp_bank[r * TD + c] = d;
                idx++;
            end
        end
        n  = idx;
        lc = (n == 0) ? 1 : n + 2;
        p  = (cmode == 1) ? 1 + (ck % (n + 1)) : (cmode == 2) ? lc + ck : -1;
        s  = empty_m ? lc + 1 : (((lc > p + 1) ? lc : p + 1) + 1);

        clear_mon();
        desc_base = base; desc_stride = stride; desc_rows = rows; desc_cols = cols;
        desc_valid = 1'b1;
        c0 = cyc;
        @(negedge clk);
        check("accept_ready", int'(desc_ready), 1);
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
        for (int t = 0; t < s + 40 && ready_after < 0; t++) begin
            rel = cyc - c0;
            consume_done = (rel == p) || (pulse_swap && rel == s);
            if (noise && n >= 8) begin
                desc_valid = (rel >= 2) && (rel <= 4);
                if (desc_valid) begin
                    desc_base   = 16'($urandom);
                    desc_stride = 16'($urandom);
                    desc_rows   = 5'($urandom);
                    desc_cols   = 5'($urandom);
                end
            end
            sample();
        end
        consume_done = 1'b0;
        desc_valid   = 1'b0;

        check("rd_count", rd_cyc.size(), e_rd_rel.size());
        ok = 1'b1;
        for (int i = 0; i < rd_cyc.size() && i < e_rd_rel.size(); i++)
            if (rd_cyc[i] - c0 != e_rd_rel[i] || rd_addr[i] !== e_rd_addr[i]) ok = 1'b0;
        check("rd_seq", int'(ok), 1);
        check("wr_count", wr_cyc.size(), e_wr_rel.size());
        ok = 1'b1;
        for (int i = 0; i < wr_cyc.size() && i < e_wr_rel.size(); i++)
            if (wr_cyc[i] - c0 != e_wr_rel[i] || wr_addr[i] !== e_wr_addr[i] ||
                wr_data[i] !== e_wr_data[i]) ok = 1'b0;
        check("wr_seq", int'(ok), 1);
        check("loaded_cycle", (loaded_cyc < 0) ? -1 : loaded_cyc - c0, lc);
        check("swap_cycle", (swap_cyc < 0) ? -1 : swap_cyc - c0, s);
        check("swap_count", nswap, 1);
        check("ready_after_swap", ready_after, 1);
        mism = 0;
        for (int i = 0; i < BD; i++) if (dut_bank[i] !== exp_bank[i]) mism++;
        check("bank_mismatch", mism, 0);
        $display("tile base=%h stride=%h rows=%0d cols=%0d N=%0d loaded=%0d swap=%0d",
                 base, stride, rows, cols, n, lc, s);
        empty_m = 1'b0;
    endtask

    initial begin
        int c0;
        logic [15:0] a;
        for (int i = 0; i < BD; i++) begin
            exp_bank[i] = 8'hAA;
            dut_bank[i] = 8'hAA;
        end
        clear_mon();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_desc_ready", int'(desc_ready), 1);
        check("reset_src_rd_en", int'(src_rd_en), 0);
        check("reset_dma_wr_en", int'(dma_wr_en), 0);
        check("reset_swap", int'(swap), 0);
        check("reset_tile_loaded", int'(tile_loaded), 0);
        check("reset_busy", int'(busy), 0);
        @(posedge clk);
        #1;

        // Full tile, swaps without consume_done
        run_tile(16'h0100, 16'd16, 5'd16, 5'd16, 0, 0, 1'b1, 1'b0);
        // Wrapping source addresses, consume after LOADED
        run_tile(16'hFFFE, 16'h0010, 5'd4, 5'd3, 2, 5, 1'b0, 1'b0);
        // Consume mid-fetch; a second pulse in the SWAP cycle must be dropped
        run_tile(16'h0340, 16'h0020, 5'd8, 5'd8, 1, 20, 1'b1, 1'b1);
        // Zero columns, rows clamped
        run_tile(16'h1234, 16'h0040, 5'd20, 5'd0, 2, 3, 1'b0, 1'b0);
        run_tile(16'h0500, 16'h0011, 5'd2, 5'd2, 2, 1, 1'b0, 1'b0);

        // Reset during cycle 50 of a full fetch
        clear_mon();
        desc_base = 16'h2000; desc_stride = 16'd16; desc_rows = 5'd16; desc_cols = 5'd16;
        desc_valid = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
        for (int t = 0; t < 60 && cyc < c0 + 50; t++) sample();
        rst_n = 1'b0;
        sample();
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_src_rd_en", int'(src_rd_en), 0);
        check("abort_dma_wr_en", int'(dma_wr_en), 0);
        check("abort_swap", int'(swap), 0);
        check("abort_desc_ready", int'(desc_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_rd_count", rd_cyc.size(), 50);
        check("abort_wr_count", wr_cyc.size(), 49);
        for (int i = 0; i < 49; i++) begin
            a = 16'(16'h2000 + (i / TD) * 16 + (i % TD));
            exp_bank[i] = a[7:0];
        end
        @(posedge clk);
        #1;
        empty_m = 1'b1;
        // compute_empty restored by reset: swaps without consume_done
        run_tile(16'h0700, 16'h0013, 5'd5, 5'd7, 0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            int cm;
            cm = 1 + int'($urandom_range(0, 1));
            run_tile(16'($urandom), 16'($urandom_range(0, 300)),
                     5'($urandom_range(0, 20)), 5'($urandom_range(0, 20)),
                     cm, (cm == 1) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 6)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
